// File: rtl/general_divider_pkg.sv
// general_divider_pkg
//   Shared defaults for the restoring divider slice.
//   DEF_WIDTH_A : dividend / quotient width
//   DEF_WIDTH_B : divisor / remainder width (1 <= WIDTH_B <= WIDTH_A)
package general_divider_pkg;
  localparam int DEF_WIDTH_A = 8;
  localparam int DEF_WIDTH_B = 4;
endpackage

// File: rtl/general_divider_if.sv
// general_divider_if
//   Groups the operand/result signals of one divider instance.
//   A, B          : dividend, divisor (driven by master)
//   Q, R, done, ra: quotient, remainder, result-valid, debug shift register
interface general_divider_if
  import general_divider_pkg::*;
#(
  parameter int WIDTH_A = DEF_WIDTH_A,
  parameter int WIDTH_B = DEF_WIDTH_B
) ();
  logic [WIDTH_A-1:0]   A;
  logic [WIDTH_B-1:0]   B;
  logic [WIDTH_A-1:0]   Q;
  logic [WIDTH_B-1:0]   R;
  logic                 done;
  logic [2*WIDTH_A-1:0] ra;

  modport master (output A, B, input Q, R, done, ra);
  modport slave  (input A, B, output Q, R, done, ra);
endinterface

// File: rtl/general_divider_div_step.sv
// div_step
//   One restoring shift-subtract step (purely combinational).
//   ra_i : current {partial remainder, dividend/quotient bits}
//   b_i  : latched divisor
//   ra_o : next shift-register value with the new quotient bit in bit 0
module div_step
  import general_divider_pkg::*;
#(
  parameter int WIDTH_A = DEF_WIDTH_A,
  parameter int WIDTH_B = DEF_WIDTH_B
) (
  input  logic [2*WIDTH_A-1:0] ra_i,
  input  logic [WIDTH_B-1:0]   b_i,
  output logic [2*WIDTH_A-1:0] ra_o
);

  logic [WIDTH_A:0]   rem_ext;
  logic [WIDTH_A:0]   b_ext;
  logic [WIDTH_A-1:0] diff;
  logic               take;

  // Shifted upper half kept one bit wider so the bit shifted out of the
  // register still takes part in the compare (matters when WIDTH_B == WIDTH_A).
  assign rem_ext = ra_i[2*WIDTH_A-1:WIDTH_A-1];
  assign b_ext   = {{(WIDTH_A+1-WIDTH_B){1'b0}}, b_i};
  assign take    = (rem_ext >= b_ext);
  // When take is set the true difference is below B, so WIDTH_A bits suffice.
  assign diff    = rem_ext[WIDTH_A-1:0] - b_ext[WIDTH_A-1:0];

  always_comb begin
    ra_o = {ra_i[2*WIDTH_A-2:0], 1'b0};
    if (take) begin
      ra_o[2*WIDTH_A-1:WIDTH_A] = diff;
      ra_o[0]                   = 1'b1;
    end
  end

endmodule

// File: rtl/general_divider.sv
// general_divider
//   Restoring shift-subtract unsigned divider, one quotient bit per clock.
//   Runs once after reset release; the result then holds until next reset.
//   clk   : clock
//   reset : asynchronous active-low reset
//   A, B  : dividend, divisor (sampled only in LOAD)
//   Q, R  : registered quotient / remainder
//   done  : Q and R valid
//   ra    : live {remainder, dividend/quotient} shift register (debug)
//
//   state | meaning
//   LOAD  | latch A and B, clear step counter
//   RUN   | one shift-subtract step per edge, WIDTH_A steps
//   DONE  | result held until reset
module general_divider
  import general_divider_pkg::*;
#(
  parameter int WIDTH_A = DEF_WIDTH_A,
  parameter int WIDTH_B = DEF_WIDTH_B
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH_A-1:0]   A,
  input  logic [WIDTH_B-1:0]   B,
  output logic [WIDTH_A-1:0]   Q,
  output logic [WIDTH_B-1:0]   R,
  output logic                 done,
  output logic [2*WIDTH_A-1:0] ra
);

  localparam int CNT_W = $clog2(WIDTH_A + 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH_A-1:0] ra_q, ra_d;
  logic [WIDTH_B-1:0]   b_q, b_d;
  logic [WIDTH_A-1:0]   q_q, q_d;
  logic [WIDTH_B-1:0]   r_q, r_d;
  logic                 done_q, done_d;
  logic [2*WIDTH_A-1:0] step_ra;

  div_step #(
    .WIDTH_A (WIDTH_A),
    .WIDTH_B (WIDTH_B)
  ) u_step (
    .ra_i (ra_q),
    .b_i  (b_q),
    .ra_o (step_ra)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      ra_q    <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ra_q    <= ra_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ra_d    = ra_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    done_d  = done_q;
    unique case (state_q)
      LOAD: begin
        b_d     = B;
        ra_d    = {{WIDTH_A{1'b0}}, A};
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        ra_d  = step_ra;
        cnt_d = cnt_q + CNT_W'(1);
        // Last step: results are taken from the freshly computed ra.
        if (cnt_q == CNT_W'(WIDTH_A - 1)) begin
          state_d = DONE;
          q_d     = step_ra[WIDTH_A-1:0];
          r_d     = step_ra[WIDTH_B+WIDTH_A-1:WIDTH_A];
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign done = done_q;
  assign ra   = ra_q;

endmodule

// File: tb/tb_general_divider.sv
module tb_general_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset8;
  logic reset16;

  general_divider_if #(.WIDTH_A(8),  .WIDTH_B(4))  if8 ();
  general_divider_if #(.WIDTH_A(16), .WIDTH_B(16)) if16 ();

  general_divider #(.WIDTH_A(8), .WIDTH_B(4)) dut8 (
    .clk   (clk),
    .reset (reset8),
    .A     (if8.A),
    .B     (if8.B),
    .Q     (if8.Q),
    .R     (if8.R),
    .done  (if8.done),
    .ra    (if8.ra)
  );

  general_divider #(.WIDTH_A(16), .WIDTH_B(16)) dut16 (
    .clk   (clk),
    .reset (reset16),
    .A     (if16.A),
    .B     (if16.B),
    .Q     (if16.Q),
    .R     (if16.R),
    .done  (if16.done),
    .ra    (if16.ra)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain integer division; divide-by-zero gives all-ones
  // quotient and the dividend as the full-width remainder.
  function automatic longint unsigned ref_q(input longint unsigned a, input longint unsigned b, input int wa);
    longint unsigned ones;
    ones = (64'd1 << wa) - 64'd1;
    return (b == 0) ? ones : a / b;
  endfunction

  function automatic longint unsigned ref_rem(input longint unsigned a, input longint unsigned b);
    return (b == 0) ? a : a % b;
  endfunction

  task automatic run8(input logic [7:0] a, input logic [3:0] b);
    int lat;
    longint unsigned eq, er;
    @(negedge clk);
    reset8 = 1'b0;
    if8.A  = a;
    if8.B  = b;
    #1;
    check_val("rst8_done", 64'(if8.done), 64'd0);
    check_val("rst8_ra",   64'(if8.ra),   64'd0);
    @(negedge clk);
    reset8 = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (if8.done) lat = i;
    end
    check_val("lat8", 64'(lat), 64'd9);
    eq = ref_q(64'(a), 64'(b), 8);
    er = ref_rem(64'(a), 64'(b));
    check_val("q8",  64'(if8.Q),  eq);
    check_val("r8",  64'(if8.R),  er & 64'hF);
    check_val("ra8", 64'(if8.ra), ((er << 8) | eq) & 64'hFFFF);
    // Operand changes after LOAD must not disturb the held result.
    if8.A = 8'($urandom);
    if8.B = 4'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_val("hold8_q",    64'(if8.Q),    eq);
    check_val("hold8_done", 64'(if8.done), 64'd1);
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b);
    int lat;
    longint unsigned eq, er;
    @(negedge clk);
    reset16 = 1'b0;
    if16.A  = a;
    if16.B  = b;
    @(negedge clk);
    reset16 = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (if16.done) lat = i;
    end
    check_val("lat16", 64'(lat), 64'd17);
    eq = ref_q(64'(a), 64'(b), 16);
    er = ref_rem(64'(a), 64'(b));
    check_val("q16",  64'(if16.Q),  eq);
    check_val("r16",  64'(if16.R),  er & 64'hFFFF);
    check_val("ra16", 64'(if16.ra), ((er << 16) | eq) & 64'hFFFF_FFFF);
  endtask

  initial begin
    reset8  = 1'b0;
    reset16 = 1'b0;
    if8.A   = '0;
    if8.B   = '0;
    if16.A  = '0;
    if16.B  = '0;
    #1;
    check_val("por_q",    64'(if8.Q),    64'd0);
    check_val("por_r",    64'(if8.R),    64'd0);
    check_val("por_done", 64'(if8.done), 64'd0);

    run8(8'h8C, 4'h9);
    check_val("d8c_q",  64'(if8.Q),  64'h0F);
    check_val("d8c_r",  64'(if8.R),  64'h5);
    check_val("d8c_ra", 64'(if8.ra), 64'h050F);

    run8(8'h8D, 4'h9);
    check_val("d8d_r", 64'(if8.R), 64'h6);
    run8(8'hFF, 4'h1);
    run8(8'h05, 4'hF);
    check_val("d05_r", 64'(if8.R), 64'h5);
    run8(8'hA7, 4'h0);
    check_val("div0_q", 64'(if8.Q), 64'hFF);
    check_val("div0_r", 64'(if8.R), 64'h7);

    // Abort in the middle of RUN, away from a clock edge.
    @(negedge clk);
    reset8 = 1'b0;
    if8.A  = 8'hE3;
    if8.B  = 4'h5;
    @(negedge clk);
    reset8 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("mid_ra_busy", 64'(if8.ra != 16'h0), 64'd1);
    #2;
    reset8 = 1'b0;
    #1;
    check_val("abort_ra",   64'(if8.ra),   64'd0);
    check_val("abort_done", 64'(if8.done), 64'd0);
    check_val("abort_q",    64'(if8.Q),    64'd0);
    check_val("abort_r",    64'(if8.R),    64'd0);
    run8(8'hE3, 4'h5);

    // Abort while holding a result.
    #3;
    reset8 = 1'b0;
    #1;
    check_val("abort_dn_done", 64'(if8.done), 64'd0);
    check_val("abort_dn_q",    64'(if8.Q),    64'd0);

    for (int bv = 0; bv < 16; bv++) begin
      run8(8'($urandom), 4'(bv));
      run8(8'($urandom), 4'(bv));
    end

    run16(16'hFFFF, 16'h0001);
    run16(16'h1234, 16'hFFFF);
    run16(16'hFFFF, 16'hFFFF);
    run16(16'hBEEF, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      run16(16'($urandom), 16'($urandom_range(1, 65535)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
